sm_rocc_accum: RTL

RoCC accumulator accelerator sitting between the RoCC command unpacker and the response packer in the source/sink datapath. Accepts a packed RoCC command message over a val/rdy port, decodes funct/rd/xd and the rs1 operand, operates on a small internal register file (write, read, accumulate, clear, multi-cycle sum), and returns `{rd, data}` response messages over a val/rdy port when `xd` is set. Processes one command at a time; SUM is multi-cycle.

---
 rtl/sm_rocc_accum_if.sv | 22 ++
 rtl/sm_rocc_accum.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sm_rocc_accum_if.sv
// rtl/sm_rocc_accum_if.sv - RoCC command/response val/rdy bundle for sm_rocc_accum
interface sm_rocc_accum_if #(
    parameter int p_rs1bits      = 32,
    parameter int p_rd_data_bits = 32
);
    logic [p_rs1bits+31:0]     cmd_msg;
    logic                      cmd_val;
    logic                      cmd_rdy;
    logic [p_rd_data_bits+4:0] resp_msg;
    logic                      resp_val;
    logic                      resp_rdy;

    modport master (
        output cmd_msg, cmd_val, resp_rdy,
        input  cmd_rdy, resp_msg, resp_val
    );

    modport slave (
        input  cmd_msg, cmd_val, resp_rdy,
        output cmd_rdy, resp_msg, resp_val
    );
endinterface

// File: rtl/sm_rocc_accum.sv
// rtl/sm_rocc_accum.sv - RoCC accumulator: small register file with write/read/accum/clear/sum
module sm_rocc_accum #(
    parameter int p_rs1bits      = 32,
    parameter int p_rd_data_bits = 32,
    parameter int p_nregs        = 4
) (
    input  logic             clk,
    input  logic             reset,
    sm_rocc_accum_if.slave   rocc
);
    localparam int IW = $clog2(p_nregs);
    localparam int D  = p_rd_data_bits;
    localparam logic [IW-1:0] LAST = IW'(p_nregs - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [D-1:0]      r_xreg [p_nregs];
    logic [D-1:0]      r_acc;
    logic [IW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [4:0]        r_rd;
    logic              r_xd;
    logic [D+4:0]      r_resp_msg;
    logic              r_resp_val;

    logic [p_rs1bits-1:0] w_rs1;
    logic [D-1:0]      w_op;
    logic [6:0]        w_funct;
    logic [IW-1:0]     w_idx;
    logic              w_xd;
    logic [4:0]        w_rd;
    logic              w_cmd_rdy;
    logic              w_fire;
    logic              w_resp_fire;
    logic              w_calc_done;
    logic [D-1:0]      w_cur;
    logic [D-1:0]      w_sum;
    logic [D-1:0]      w_data;
    logic              w_unused_bits;

    assign w_rs1   = rocc.cmd_msg[p_rs1bits+31:32];
    assign w_funct = rocc.cmd_msg[31:25];
    assign w_idx   = rocc.cmd_msg[20+IW-1:20];
    assign w_xd    = rocc.cmd_msg[14];
    assign w_rd    = rocc.cmd_msg[11:7];
    assign w_unused_bits = ^rocc.cmd_msg;

    generate
        if (p_rs1bits >= D) begin : g_trunc
            assign w_op = w_rs1[D-1:0];
        end else begin : g_zext
            assign w_op = {{(D-p_rs1bits){1'b0}}, w_rs1};
        end
    endgenerate

    // Ready is held low while reset is asserted even though the state is already IDLE.
    assign w_cmd_rdy   = (r_state == ST_IDLE) && reset;
    assign w_fire      = rocc.cmd_val && w_cmd_rdy;
    assign w_resp_fire = rocc.resp_rdy && r_resp_val;
    assign w_calc_done = (r_state == ST_CALC) && (r_cnt == LAST);
    assign w_cur       = r_xreg[w_idx];
    assign w_sum       = r_acc + r_xreg[r_cnt];

    assign rocc.cmd_rdy  = w_cmd_rdy;
    assign rocc.resp_msg = r_resp_msg;
    assign rocc.resp_val = r_resp_val;

    always_comb begin
        w_data = '0;
        case (w_funct)
            7'd0:    w_data = w_op;
            7'd1:    w_data = w_cur;
            7'd2:    w_data = w_cur + w_op;
            default: w_data = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (w_funct == 7'd4) w_next = ST_CALC;
                    else if (w_xd)       w_next = ST_RESP;
                end
            end
            ST_CALC: begin
                if (w_calc_done) w_next = r_xd ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                if (w_resp_fire) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_nregs; i++) r_xreg[i] <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rd       <= '0;
            r_xd       <= 1'b0;
            r_resp_msg <= '0;
            r_resp_val <= 1'b0;
        end else begin
            if (w_fire) begin
                r_idx <= w_idx;
                r_rd  <= w_rd;
                r_xd  <= w_xd;
                r_acc <= '0;
                r_cnt <= '0;
                case (w_funct)
                    7'd0: r_xreg[w_idx] <= w_op;
                    7'd2: r_xreg[w_idx] <= w_cur + w_op;
                    7'd3: for (int i = 0; i < p_nregs; i++) r_xreg[i] <= '0;
                    default: ;
                endcase
                if (w_funct != 7'd4 && w_xd) begin
                    r_resp_msg <= {w_rd, w_data};
                    r_resp_val <= 1'b1;
                end
            end
            if (r_state == ST_CALC) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + IW'(1);
                if (w_calc_done) begin
                    r_xreg[r_idx] <= w_sum;
                    if (r_xd) begin
                        r_resp_msg <= {r_rd, w_sum};
                        r_resp_val <= 1'b1;
                    end
                end
            end
            if (w_resp_fire) r_resp_val <= 1'b0;
        end
    end
endmodule
